// File: rtl/demux_1to4_reg_pkg.sv
// ============================================================================
// Module : demux_1to4_reg_pkg
// Brief  : Shared constants, types and sel decode for the 1-to-4 demux.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package demux_1to4_reg_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SEL_W     = 2;
  localparam int NUM_OUT   = 4;

  localparam logic [SEL_W-1:0] SINK_WB  = 2'd0;
  localparam logic [SEL_W-1:0] SINK_CSR = 2'd1;
  localparam logic [SEL_W-1:0] SINK_PC  = 2'd2;
  localparam logic [SEL_W-1:0] SINK_DBG = 2'd3;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [NUM_OUT-1:0] sink_vec_t;

  function automatic sink_vec_t sel_onehot(input sel_t sel);
    sink_vec_t v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
// Module : demux_slot
// Brief  : One-entry valid/data holding register with load and drain.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demux_slot
  import demux_1to4_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             drain_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             can_load_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // A same-cycle drain frees the slot, allowing full-rate streaming.
  assign can_load_o = ~valid_q | drain_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (valid_q && drain_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/demux_1to4_reg.sv
// ============================================================================
// Module : demux_1to4_reg
// Brief  : Registered 1-to-4 valid/ready demultiplexer, one slot per sink.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demux_1to4_reg
  import demux_1to4_reg_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NUM_OUT = demux_1to4_reg_pkg::NUM_OUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [SEL_W-1:0]         in_sel_i,
  input  logic [WIDTH-1:0]         in_data_i,
  output logic [NUM_OUT-1:0]       out_valid_o,
  input  logic [NUM_OUT-1:0]       out_ready_i,
  output logic [NUM_OUT*WIDTH-1:0] out_data_o,
  output logic                     busy_o
);

  logic [NUM_OUT-1:0] can_load;
  logic [NUM_OUT-1:0] load_vec;
  logic               accept;

  // in_ready never looks at in_valid, so the source may gate valid on ready.
  assign in_ready_o = rst_n & can_load[in_sel_i];
  assign accept     = in_valid_i & in_ready_o;
  assign load_vec   = sel_onehot(in_sel_i) & {NUM_OUT{accept}};

  generate
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
      demux_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (load_vec[i]),
        .load_data_i   (in_data_i),
        .drain_ready_i (out_ready_i[i]),
        .valid_o       (out_valid_o[i]),
        .data_o        (out_data_o[i*WIDTH +: WIDTH]),
        .can_load_o    (can_load[i])
      );
    end
  endgenerate

  assign busy_o = |out_valid_o;

endmodule

`default_nettype wire
